// File: rtl/color_sequencer.sv
// Avalon-MM LED colour sequencer: plays a table of (colour, duration) steps
// on out_port with a shared prescaler, in one-shot or loop mode.
module color_sequencer #(
    parameter int DEPTH      = 8,
    parameter int PRESCALE_W = 16,
    parameter int DUR_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  out_port,
    output logic        irq
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PRESCALE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]        dcnt_q, dcnt_d;
    logic [DUR_W-1:0]        cur_dur_q, cur_dur_d;
    logic [1:0]              out_q, out_d;
    logic                    done_q, done_d;
    logic                    loop_q, loop_d;
    logic                    irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic [4:0]              len_q, len_d;
    logic [1:0]              manual_q, manual_d;
    logic [1:0]              col_q [DEPTH];
    logic [1:0]              col_d [DEPTH];
    logic [DUR_W-1:0]        dur_q [DEPTH];
    logic [DUR_W-1:0]        dur_d [DEPTH];

    logic                    wr;
    logic                    hit_ctrl, hit_stat, hit_pre, hit_len, hit_man;
    logic                    ent_hit;
    logic [IDX_W-1:0]        ent_idx;
    logic                    start, stop;
    logic [PRESCALE_W-1:0]   ps_m1;
    logic                    tick, step_end, last;
    logic [5:0]              len_eff;
    logic                    ld;
    logic [IDX_W-1:0]        ld_idx;
    logic                    unused_ok;

    function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign unused_ok = &{1'b0, writedata};

    assign wr       = chipselect & ~write_n;
    assign hit_ctrl = (address == 5'd0);
    assign hit_stat = (address == 5'd1);
    assign hit_pre  = (address == 5'd2);
    assign hit_len  = (address == 5'd3);
    assign hit_man  = (address == 5'd4);
    assign ent_hit  = address[4] && ({1'b0, address[3:0]} < 5'(DEPTH));
    assign ent_idx  = address[IDX_W-1:0];

    assign start = wr & hit_ctrl & writedata[0] & ~writedata[1];
    assign stop  = wr & hit_ctrl & writedata[1];

    // Prescale of 0 behaves as 1: terminal count is then 0 every cycle.
    assign ps_m1    = (prescale_q == '0) ? '0 : prescale_q - PRESCALE_W'(1);
    assign tick     = (pre_q >= ps_m1);
    assign step_end = tick &&
        (({1'b0, dcnt_q} + (DUR_W+1)'(1)) >= {1'b0, cur_dur_q});

    always_comb begin
        len_eff = {1'b0, len_q};
        if (len_q == '0)
            len_eff = 6'd1;
        else if ({1'b0, len_q} > 6'(DEPTH))
            len_eff = 6'(DEPTH);
    end

    assign last = (6'(idx_q) + 6'd1) >= len_eff;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pre_d      = pre_q;
        dcnt_d     = dcnt_q;
        cur_dur_d  = cur_dur_q;
        out_d      = out_q;
        done_d     = done_q;
        loop_d     = loop_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        len_d      = len_q;
        manual_d   = manual_q;
        col_d      = col_q;
        dur_d      = dur_q;
        ld         = 1'b0;
        ld_idx     = '0;

        if (wr && hit_ctrl) begin
            loop_d   = writedata[2];
            irq_en_d = writedata[3];
        end
        if (wr && hit_stat && writedata[1])
            done_d = 1'b0;
        if (wr && hit_pre)
            prescale_d = writedata[PRESCALE_W-1:0];
        if (wr && hit_len)
            len_d = writedata[4:0];
        if (wr && hit_man)
            manual_d = writedata[1:0];
        for (int i = 0; i < DEPTH; i++) begin
            if (wr && ent_hit && ent_idx == IDX_W'(i)) begin
                col_d[i] = writedata[1:0];
                dur_d[i] = writedata[8 +: DUR_W];
            end
        end

        unique case (state_q)
            IDLE: begin
                out_d = manual_d;
                if (start)
                    ld = 1'b1;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    out_d   = manual_d;
                end else if (start) begin
                    ld = 1'b1;
                end else if (step_end) begin
                    if (!last) begin
                        ld     = 1'b1;
                        ld_idx = idx_q + IDX_W'(1);
                    end else if (loop_q) begin
                        ld = 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        out_d   = manual_d;
                        done_d  = 1'b1;
                    end
                end else if (tick) begin
                    pre_d  = '0;
                    dcnt_d = dcnt_q + DUR_W'(1);
                end else begin
                    pre_d = pre_q + PRESCALE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Colour and duration come from the table contents before this cycle's write.
        if (ld) begin
            state_d   = RUN;
            idx_d     = ld_idx;
            pre_d     = '0;
            dcnt_d    = '0;
            out_d     = col_q[ld_idx];
            cur_dur_d = dur_eff(dur_q[ld_idx]);
            if (start)
                done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pre_q      <= '0;
            dcnt_q     <= '0;
            cur_dur_q  <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
            loop_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            len_q      <= '0;
            manual_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                col_q[i] <= '0;
                dur_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pre_q      <= pre_d;
            dcnt_q     <= dcnt_d;
            cur_dur_q  <= cur_dur_d;
            out_q      <= out_d;
            done_q     <= done_d;
            loop_q     <= loop_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            len_q      <= len_d;
            manual_q   <= manual_d;
            col_q      <= col_d;
            dur_q      <= dur_d;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (1'b1)
            hit_ctrl: readdata[3:2] = {irq_en_q, loop_q};
            hit_stat: begin
                readdata[0]   = (state_q == RUN);
                readdata[1]   = done_q;
                readdata[7:4] = 4'(idx_q);
            end
            hit_pre: readdata[PRESCALE_W-1:0] = prescale_q;
            hit_len: readdata[4:0] = len_q;
            hit_man: readdata[1:0] = manual_q;
            ent_hit: begin
                readdata[1:0]       = col_q[ent_idx];
                readdata[8 +: DUR_W] = dur_q[ent_idx];
            end
            default: readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer: register map, one-shot, loop,
// edge values, start/stop collision, restart and asynchronous reset.
module tb_color_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  out_port;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    color_sequencer #(.DEPTH(8), .PRESCALE_W(16), .DUR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] ec;
        logic [3:0] ei;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {30'b0, out_port}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("rst_ctrl", 5'd0, 32'h0);
        rd_chk("rst_stat", 5'd1, 32'h0);
        rd_chk("rst_pre", 5'd2, 32'h0);
        rd_chk("rst_len", 5'd3, 32'h0);
        rd_chk("rst_man", 5'd4, 32'h0);
        rd_chk("rst_e0", 5'd16, 32'h0);
        rd_chk("rst_e7", 5'd23, 32'h0);

        wr(5'd4, 32'h2);
        chk("man_out", {30'b0, out_port}, 32'h2);
        rd_chk("man_busy", 5'd1, 32'h0);

        // One-shot: 1 for 8, 2 for 4, 3 for 12 cycles.
        wr(5'd2, 32'd4);
        wr(5'd3, 32'd3);
        wr(5'd16, 32'h201);
        wr(5'd17, 32'h102);
        wr(5'd18, 32'h303);
        rd_chk("e1_rb", 5'd17, 32'h102);
        wr(5'd0, 32'h9);
        address = 5'd1;
        #1;
        for (int i = 0; i < 24; i++) begin
            ec = (i < 8) ? 2'd1 : (i < 12) ? 2'd2 : 2'd3;
            ei = (i < 8) ? 4'd0 : (i < 12) ? 4'd1 : 4'd2;
            chk($sformatf("os_col%0d", i), {30'b0, out_port}, {30'b0, ec});
            chk($sformatf("os_st%0d", i), readdata, {24'b0, ei, 4'h1});
            step();
        end
        chk("os_man", {30'b0, out_port}, 32'h2);
        chk("os_done", readdata, 32'h2);
        chk("os_irq", {31'b0, irq}, 32'h1);
        rd_chk("os_ctrl", 5'd0, 32'h8);
        wr(5'd1, 32'h2);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        rd_chk("w1c_stat", 5'd1, 32'h0);

        // Loop mode over three 24-cycle periods, then stop.
        wr(5'd0, 32'hD);
        address = 5'd1;
        #1;
        for (int i = 0; i < 72; i++) begin
            ec = ((i % 24) < 8) ? 2'd1 : ((i % 24) < 12) ? 2'd2 : 2'd3;
            chk($sformatf("lp_col%0d", i), {30'b0, out_port}, {30'b0, ec});
            chk($sformatf("lp_st%0d", i), {30'b0, readdata[1:0]}, 32'h1);
            step();
        end
        chk("lp_wrap", {30'b0, out_port}, 32'h1);
        wr(5'd0, 32'hE);
        chk("stop_out", {30'b0, out_port}, 32'h2);
        rd_chk("stop_stat", 5'd1, 32'h0);
        chk("stop_irq", {31'b0, irq}, 32'h0);

        // Zero prescale, length and duration: one cycle then done.
        wr(5'd2, 32'd0);
        wr(5'd3, 32'd0);
        wr(5'd16, 32'h001);
        wr(5'd0, 32'h1);
        chk("z_col", {30'b0, out_port}, 32'h1);
        step();
        chk("z_man", {30'b0, out_port}, 32'h2);
        rd_chk("z_stat", 5'd1, 32'h2);
        rd_chk("z_ctrl", 5'd0, 32'h0);

        // LENGTH=31 plays exactly the 8 table entries.
        wr(5'd2, 32'd1);
        wr(5'd3, 32'd31);
        rd_chk("len_rb", 5'd3, 32'd31);
        for (int i = 0; i < 8; i++)
            wr(5'(16 + i), 32'h100 | 32'((i + 1) & 3));
        wr(5'd0, 32'h1);
        address = 5'd1;
        #1;
        for (int i = 0; i < 8; i++) begin
            ec = 2'((i + 1) & 3);
            chk($sformatf("cl_col%0d", i), {30'b0, out_port}, {30'b0, ec});
            step();
        end
        chk("cl_man", {30'b0, out_port}, 32'h2);
        chk("cl_stat", readdata, 32'h2);

        wr(5'd0, 32'h3);
        chk("ss_out", {30'b0, out_port}, 32'h2);
        address = 5'd1;
        #1;
        chk("ss_busy", {31'b0, readdata[0]}, 32'h0);

        // Restart in the middle of step 1.
        wr(5'd2, 32'd2);
        wr(5'd3, 32'd2);
        wr(5'd16, 32'h301);
        wr(5'd17, 32'h203);
        wr(5'd0, 32'h1);
        address = 5'd1;
        #1;
        for (int i = 0; i < 8; i++) begin
            ec = (i < 6) ? 2'd1 : 2'd3;
            chk($sformatf("rs_a%0d", i), {30'b0, out_port}, {30'b0, ec});
            step();
        end
        wr(5'd0, 32'h1);
        address = 5'd1;
        #1;
        for (int i = 0; i < 7; i++) begin
            ec = (i < 6) ? 2'd1 : 2'd3;
            chk($sformatf("rs_b%0d", i), {30'b0, out_port}, {30'b0, ec});
            step();
        end
        chk("rs_busy", readdata, 32'h11);

        #1;
        reset = 1'b1;
        #1;
        chk("ar_out", {30'b0, out_port}, 32'h0);
        chk("ar_stat", readdata, 32'h0);
        chk("ar_irq", {31'b0, irq}, 32'h0);
        rd_chk("ar_man", 5'd4, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("ar_idle", {30'b0, out_port}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
- Avalon-MM slave that sequences the 2-bit LED color output without per-step CPU writes.
- NIOS II loads a pattern table of (color, duration) steps, sets a prescaler, and starts the sequence.
- The block steps through the table in one-shot or loop mode, then raises a done interrupt.
- While idle, out_port shows a CPU-written manual color. The block replaces direct PIO-driven color writes.

Parameters:
- DEPTH, 8, number of pattern table entries (power of 2, 2..16).
- PRESCALE_W, 16, prescaler register width (1 time unit = PRESCALE clk cycles).
- DUR_W, 8, per-step duration field width, in time units.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- address  input  5  word address: 0..4 control registers, 16..16+DEPTH-1 table entries.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe. Writes take effect when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  combinational read data, zero wait states. Unmapped bits and addresses read 0.
- out_port  output  2  registered LED color.
- irq  output  1  level interrupt, equal to done AND irq_en.

Behaviour:
Clock and reset:
- One clock (clk). Reset is asynchronous and active-high (reset).
- Reset values: out_port=0, irq=0, state=IDLE, all registers 0, table entries 0.

Register map:
- 0 CTRL (W): bit0 start (pulse), bit1 stop (pulse), bit2 loop, bit3 irq_en. Reads return {irq_en, loop} in bits 3:2; bits 1:0 read 0.
- 1 STATUS (R): bit0 busy, bit1 done (sticky), bits[7:4] current index. Writing 1 to bit1 clears done. Other written bits are ignored.
- 2 PRESCALE (RW): bits[PRESCALE_W-1:0]. A value of 0 is treated as 1.
- 3 LENGTH (RW): bits[4:0], number of active steps. 0 is treated as 1; values above DEPTH are clamped to DEPTH.
- 4 MANUAL (RW): bits[1:0], color shown when not RUN.
- 16+i ENTRY[i] (RW): bits[1:0] color, bits[8+DUR_W-1:8] duration. Duration 0 is treated as 1.

FSM states IDLE, RUN:
- IDLE: out_port=MANUAL, registered, updates 1 cycle after the MANUAL write.
- Start write in cycle N:
  - Enter RUN at N+1, with out_port=ENTRY[0].color, index=0, prescale and duration counters cleared.
  - done is cleared.
- Start while in RUN: restart from entry 0 with the same timing.
- Start and stop in the same write: stop wins.
- RUN timing:
  - Prescaler counts 0..PRESCALE-1 and emits a 1-cycle tick at terminal count.
  - The duration counter increments on each tick.
  - When it reaches ENTRY[index].duration, the step ends. The step lasts duration*PRESCALE cycles exactly.
- Step end, not the last step: index+1, out_port=ENTRY[index+1].color on the next cycle, counters cleared.
- Step end, last step (index=LENGTH_eff-1):
  - loop=1: index wraps to 0, continuing seamlessly with no gap cycle.
  - loop=0: go to IDLE, out_port=MANUAL, done=1.
- Stop write: go to IDLE next cycle, out_port=MANUAL. done is not set.
- Color and duration are latched at step load. Table writes during RUN affect only steps loaded afterwards.
- LENGTH and loop are sampled live, at each step end.
- If LENGTH is reduced below index+1 during RUN, the current step is treated as last.
- done clear (W1C) in the same cycle as done being set: set wins.
- busy=1 exactly in RUN.
- Reset mid-RUN: immediate return to reset values. No done and no irq.

Test Plan:
- Reset, then read all registers → all 0. out_port=0, irq=0.
- MANUAL=2 → out_port=2 one cycle after the write. STATUS.busy=0.
- PRESCALE=4, LENGTH=3, ENTRY0={1,dur2}, ENTRY1={2,dur1}, ENTRY2={3,dur3}, irq_en=1, start → out_port holds 1 for 8 cycles, 2 for 4 cycles, 3 for 12 cycles. Then MANUAL appears, done=1, irq=1. W1C of STATUS bit1 drops irq next cycle.
- Same table with loop=1 → after entry 2 the sequence returns to color 1 with no gap cycle. Period is 24 cycles over 3 periods. done stays 0. Stop write → MANUAL next cycle, busy=0, done=0.
- Edge values: PRESCALE=0, LENGTH=0, ENTRY0 duration=0 → color shown for exactly 1 cycle, then done. LENGTH=31 is clamped to DEPTH=8 steps.
- Start and stop in the same write → remains IDLE. Restart mid-step-1 → entry 0 reloads with full duration. Reset asserted mid-RUN → out_port=0 asynchronously, busy=0.
